fp_div_seq: RTL and testbench
=============================

FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 The block SHALL have no parameters; the format is IEEE-754 binary32, with FP_WIDTH=32, EXP_WIDTH=8, MANT_WIDTH=23 and BIAS=127.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 dividend  input  32  binary32 numerator.
REQ-008 divisor  input  32  binary32 denominator.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  32  binary32 quotient.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, EXP, ITER, NORM and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; an operand pair is accepted when in_valid and in_ready are both high on a clock edge.
REQ-015 On acceptance, the block SHALL register dividend and divisor and go to EXP; operand changes after acceptance SHALL have no effect.
REQ-016 In EXP, the block SHALL compute sign = sa^sb and a 10-bit signed exponent e = ea - eb + 127.
REQ-017 In EXP, the block SHALL classify the operands in priority order, go to DONE, and skip ITER/NORM:
- either exponent == 255, or both operands zero -> result 0x7FC00000;
- divisor zero -> {sign, 0xFF, 0};
- dividend zero -> {sign, 31'b0}.
REQ-018 Subnormal inputs (exp == 0, mant != 0) SHALL be flushed to signed zero before classification.
REQ-019 For normal operands, EXP SHALL load:
- remainder (25 bits) = {1'b0, 1, mant_a};
- mb = {1, mant_b};
- an iteration counter = 0.
REQ-020 ITER SHALL last exactly 25 cycles and produce one quotient bit per cycle, MSB first:
- if remainder >= mb: qbit = 1 and remainder = (remainder - mb) << 1;
- otherwise: qbit = 0 and remainder = remainder << 1.
REQ-021 The counter SHALL run 0..24; ITER SHALL go to NORM when counter == 24.
REQ-022 In NORM, if q[24] == 1, then mantissa = q[23:1] and the exponent is e; otherwise mantissa = q[22:0] and the exponent is e - 1. Rounding SHALL be truncation (no rounding).
REQ-023 In NORM, after normalization:
- exponent >= 255 -> {sign, 0xFF, 0};
- exponent <= 0 -> {sign, 31'b0};
- otherwise -> {sign, exponent[7:0], mantissa}.
REQ-024 Latency: with acceptance at edge t, out_valid SHALL rise at t+28 for normal operands and at t+2 for special operands.
REQ-025 In DONE, out_valid SHALL be 1 and result SHALL be stable until the edge where out_ready = 1; at that edge the block SHALL return to IDLE.
REQ-026 The block SHALL NOT accept a new operand in the same cycle it delivers a result.
REQ-027 result SHALL hold its last value outside DONE, but only out_valid qualifies it.

Reset
REQ-028 While rst = 1 at a clock edge, the block SHALL reset to IDLE with in_ready = 1, out_valid = 0, busy = 0, result = 0 and counter = 0.
REQ-029 Reset SHALL take priority over all other inputs, including a handshake in the same cycle.
REQ-030 Reset asserted mid-ITER or in DONE SHALL abort the operation; the aborted result SHALL never be presented.

Verification
REQ-031 Scenario: 0x40C00000 / 0x40000000 with out_ready = 1 -> result 0x40400000, out_valid at t+28 for exactly one cycle.
REQ-032 Scenario: 0x3F800000 / 0x40400000 -> 0x3EAAAAAA (truncated).
REQ-033 Scenario: 0xBF800000 / 0x00000000 -> 0xFF800000 at t+2; 0x00000000 / 0x00000000 -> 0x7FC00000 at t+2.
REQ-034 Scenario: 0x7F000000 / 0x3E800000 -> 0x7F800000 (overflow); 0x00800000 / 0x40000000 -> 0x00000000 (underflow).
REQ-035 Scenario: out_ready held 0 for 10 cycles in DONE -> result and out_valid stable, in_ready = 0, new in_valid ignored; out_ready = 1 -> IDLE on the next edge.
REQ-036 Scenario: rst pulsed at ITER counter == 12, then 0x40000000 / 0x3F800000 issued -> no stale out_valid, and 0x40000000 at t+28.

Source files
------------

// File: rtl/fp_div_seq.sv
// Sequential binary32 divider: restoring division, one quotient bit per cycle.
// Results are truncated, subnormal inputs and outputs flush to zero, and any NaN or Inf input gives a quiet NaN.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, EXP, ITER, NORM, DONE
  } state_t;

  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] res_q, res_d;
  logic        sign_q, sign_d;
  logic signed [9:0] e_q, e_d;
  logic [24:0] rem_q, rem_d, q_q, q_d;
  logic [23:0] mb_q, mb_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [7:0]  ea, eb;
  logic        a_zero, b_zero, nan, sgn, ge;
  logic [24:0] rem_sub;
  logic signed [9:0] e_n;
  logic [22:0] mant_n;

  assign ea      = a_q[30:23];
  assign eb      = b_q[30:23];
  assign a_zero  = (ea == 8'd0);
  assign b_zero  = (eb == 8'd0);
  assign nan     = (ea == 8'hFF) || (eb == 8'hFF) || (a_zero && b_zero);
  assign sgn     = a_q[31] ^ b_q[31];
  assign ge      = (rem_q >= {1'b0, mb_q});
  assign rem_sub = rem_q - {1'b0, mb_q};
  assign e_n     = q_q[24] ? e_q : e_q - 10'sd1;
  assign mant_n  = q_q[24] ? q_q[23:1] : q_q[22:0];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = res_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sign_d  = sign_q;
    e_d     = e_q;
    rem_d   = rem_q;
    q_d     = q_q;
    mb_d    = mb_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = dividend;
          b_d     = divisor;
          state_d = EXP;
        end
      end
      EXP: begin
        sign_d = sgn;
        e_d    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        if (nan) begin
          res_d   = 32'h7FC0_0000;
          state_d = DONE;
        end else if (b_zero) begin
          res_d   = {sgn, 8'hFF, 23'd0};
          state_d = DONE;
        end else if (a_zero) begin
          res_d   = {sgn, 31'd0};
          state_d = DONE;
        end else begin
          rem_d   = {2'b01, a_q[22:0]};
          mb_d    = {1'b1, b_q[22:0]};
          q_d     = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        q_d   = {q_q[23:0], ge};
        rem_d = ge ? {rem_sub[23:0], 1'b0} : {rem_q[23:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) state_d = NORM;
      end
      NORM: begin
        if (e_n >= 10'sd255)
          res_d = {sign_q, 8'hFF, 23'd0};
        else if (e_n <= 10'sd0)
          res_d = {sign_q, 31'd0};
        else
          res_d = {sign_q, e_n[7:0], mant_n};
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sign_q  <= 1'b0;
      e_q     <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sign_q  <= sign_d;
      e_q     <= e_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed and random operands checked against an integer-division model.
// Latency k is the number of edges after acceptance before out_valid is first seen; it is sampled high at edge t+k+1.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fp_div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [31:0] a,
                                    input logic [31:0] b);
    return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) ||
           (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
  endfunction

  // Quotient of the significands as a value scaled by 2^24, then truncated.
  function automatic logic [31:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, q;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255 || (ea == 0 && eb == 0))
      return 32'h7FC0_0000;
    if (eb == 0) return {s, 8'hFF, 23'd0};
    if (ea == 0) return {s, 31'd0};
    ma = longint'(a[22:0]) + (64'd1 << 23);
    mb = longint'(b[22:0]) + (64'd1 << 23);
    q  = (ma << 24) / mb;
    e  = ea - eb + 127;
    if (q < (64'd1 << 24)) e = e - 1;
    else q = q >> 1;
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], q[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] exp_r;
    int lat, k;
    exp_r = ref_div(a, b);
    lat   = is_special(a, b) ? 1 : 27;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    k = 0;
    do begin
      @(posedge clk);
      k++;
      #1;
    end while (!out_valid && k < 40);
    chk("latency", 32'(k), 32'(lat));
    chk("result", result, exp_r);
    chk("busy_done", {31'd0, busy}, 32'd1);
    chk("in_ready_done", {31'd0, in_ready}, 32'd0);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        dividend = $urandom;
        divisor  = $urandom;
        @(posedge clk);
        #1;
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_result", result, exp_r);
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    chk("back_idle", {31'd0, in_ready}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("result_kept", result, exp_r);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    dividend = 32'h40C0_0000;
    divisor  = 32'h4000_0000;
    @(posedge clk);
    #1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset("reset");

    run_op(32'h40C0_0000, 32'h4000_0000, 0);
    run_op(32'h3F80_0000, 32'h4040_0000, 0);
    run_op(32'hBF80_0000, 32'h0000_0000, 0);
    run_op(32'h0000_0000, 32'h0000_0000, 0);
    run_op(32'h7F00_0000, 32'h3E80_0000, 0);
    run_op(32'h0080_0000, 32'h4000_0000, 0);
    run_op(32'h7F80_0000, 32'h3F80_0000, 0);
    run_op(32'h0000_1234, 32'hC000_0000, 0);
    run_op(32'h3F80_0000, 32'h0040_0000, 0);
    run_op(32'h4049_0FDB, 32'h402D_F854, 10);

    // Abort mid-ITER at counter 12, then a clean operation.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'h4000_0000;
    divisor  = 32'h4040_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    do_reset("abort_iter");
    run_op(32'h4000_0000, 32'h3F80_0000, 0);

    // Abort while a result is waiting in DONE.
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    dividend  = 32'hBF80_0000;
    divisor   = 32'h0000_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    do_reset("abort_done");
    out_ready = 1'b1;

    for (int i = 0; i < 20; i++) begin
      ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      run_op(ra, rb, (i % 5 == 0) ? 2 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i[0]) ra[30:23] = (i[1]) ? 8'hFF : 8'h00;
      else      rb[30:23] = (i[1]) ? 8'hFF : 8'h00;
      run_op(ra, rb, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
